// File: rtl/alu_mode_ctrl.sv
// alu_mode_ctrl: board-level mode/operation selector with synchronised inputs,
// debounced mode-advance button, registered ALU result and timed LED patterns.
// Ports:
//   ADC_CLK_10   - system clock (rising edge)
//   RST_N        - asynchronous active-low reset
//   key_adv_n    - raw active-low mode-advance button (asynchronous)
//   op_a, op_b   - W-bit operands (asynchronous switches)
//   sub_sel      - 2-bit sub-operation select (asynchronous switches)
//   mode         - current mode: 0 COMPARE, 1 LOGIC, 2 ARITH, 3 PATTERN
//   result       - registered 2W-bit result, zero-extended
//   result_valid - result reflects current mode and inputs
//   led          - registered LED drive
//   mode_changed - one-cycle pulse aligned with each new mode value
// Optional feature macro: AUTO_CYCLE_EN (periodic auto-advance timer, AUTO_PERIOD).
module alu_mode_ctrl #(
  parameter int unsigned W               = 4,
  parameter int unsigned LED_W           = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned PATTERN_DIV     = 1000000
`ifdef AUTO_CYCLE_EN
  , parameter int unsigned AUTO_PERIOD   = 50000000
`endif
) (
  input  logic             ADC_CLK_10,
  input  logic             RST_N,
  input  logic             key_adv_n,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic [1:0]       sub_sel,
  output logic [1:0]       mode,
  output logic [2*W-1:0]   result,
  output logic             result_valid,
  output logic [LED_W-1:0] led,
  output logic             mode_changed
);

  localparam int unsigned RW   = 2 * W;
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PD_W = (PATTERN_DIV > 1) ? $clog2(PATTERN_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PD_W-1:0] PD_LAST = PD_W'(PATTERN_DIV - 1);

  localparam logic [1:0] MODE_COMPARE = 2'd0;
  localparam logic [1:0] MODE_LOGIC   = 2'd1;
  localparam logic [1:0] MODE_ARITH   = 2'd2;
  localparam logic [1:0] MODE_PATTERN = 2'd3;

  logic [1:0]       key_sync_q;
  logic             key_db_q, key_db_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [W-1:0]     a_q, b_q;
  logic [1:0]       sel_q;
  logic [1:0]       mode_q, mode_d;
  logic             mode_chg_q;
  logic [RW-1:0]    result_q, result_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [1:0]       settle_q, settle_d;
  logic             valid_q, valid_d;
  logic [PD_W-1:0]  pre_q, pre_d;
  logic             dir_up_q, dir_up_d;

  logic             press_c, adv_c, step_c, led_onehot_c;
  logic [RW-1:0]    res_c;
  logic [W:0]       sum_c, diff_c, shl_c;
  logic [W-1:0]     not_a_c, max_c;
  logic [RW-1:0]    prod_c;

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    key_db_d = key_db_q;
    db_cnt_d = '0;
    press_c  = 1'b0;
    if (key_sync_q[1] != key_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        key_db_d = key_sync_q[1];
        press_c  = ~key_sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

`ifdef AUTO_CYCLE_EN
  localparam int unsigned AP_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AP_W-1:0] AP_LAST = AP_W'(AUTO_PERIOD - 1);

  logic [AP_W-1:0] auto_q, auto_d;
  logic            auto_c;

  // Free-running advance timer; a real press restarts it.
  always_comb begin
    auto_c = (auto_q == AP_LAST);
    auto_d = auto_q + AP_W'(1);
    if (press_c || auto_c) auto_d = '0;
  end

  always_ff @(posedge ADC_CLK_10 or negedge RST_N) begin
    if (!RST_N) auto_q <= '0;
    else        auto_q <= auto_d;
  end

  assign adv_c = press_c | auto_c;
`else
  assign adv_c = press_c;
`endif

  // Operation datapath on the registered inputs.
  assign sum_c   = {1'b0, a_q} + {1'b0, b_q};
  assign diff_c  = {1'b0, a_q} - {1'b0, b_q};
  assign shl_c   = {a_q, 1'b0};
  assign prod_c  = RW'(a_q) * RW'(b_q);
  assign not_a_c = ~a_q;
  assign max_c   = (a_q > b_q) ? a_q : b_q;

  always_comb begin
    res_c = '0;
    case (mode_q)
      MODE_COMPARE: begin
        case (sel_q)
          2'd0:    res_c = RW'(a_q == b_q);
          2'd1:    res_c = RW'(a_q > b_q);
          2'd2:    res_c = RW'(a_q < b_q);
          default: res_c = RW'(max_c);
        endcase
      end
      MODE_LOGIC: begin
        case (sel_q)
          2'd0:    res_c = RW'(a_q & b_q);
          2'd1:    res_c = RW'(a_q | b_q);
          2'd2:    res_c = RW'(a_q ^ b_q);
          default: res_c = RW'(not_a_c);
        endcase
      end
      MODE_ARITH: begin
        case (sel_q)
          2'd0:    res_c = RW'(sum_c);
          2'd1:    res_c = RW'(diff_c);
          2'd2:    res_c = prod_c;
          default: res_c = RW'(shl_c);
        endcase
      end
      default: res_c = '0;
    endcase
  end

  assign led_onehot_c = (led_q != '0) && ((led_q & (led_q - LED_W'(1))) == '0);
  assign step_c       = (pre_q == PD_LAST);

  // Mode, result, valid tracking and LED pattern engine; an advance overrides a pattern step.
  always_comb begin
    mode_d   = mode_q;
    result_d = res_c;
    led_d    = led_q;
    pre_d    = pre_q;
    dir_up_d = dir_up_q;
    // settle counts 1,2 after a change; valid once it has sat at 2 for a cycle.
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    valid_d  = (settle_q == 2'd2);
    if (adv_c) begin
      mode_d   = mode_q + 2'd1;
      settle_d = 2'd1;
      valid_d  = 1'b0;
      pre_d    = '0;
      dir_up_d = 1'b1;
      led_d    = (mode_q == MODE_ARITH) ? LED_W'(1) : '0;
    end else if (mode_q == MODE_PATTERN) begin
      pre_d = step_c ? '0 : pre_q + PD_W'(1);
      if ((sel_q == 2'd0 || sel_q == 2'd1) && !led_onehot_c) begin
        led_d = LED_W'(1);
      end else if (step_c) begin
        case (sel_q)
          2'd0: begin
            if (dir_up_q) begin
              if (led_q[LED_W-1]) begin
                led_d    = led_q >> 1;
                dir_up_d = 1'b0;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                led_d    = led_q << 1;
                dir_up_d = 1'b1;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          2'd1:    led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
          2'd2:    led_d = led_q + LED_W'(1);
          default: led_d = led_q;
        endcase
      end
    end else if (mode_q == MODE_ARITH) begin
      led_d    = '0;
      led_d[0] = res_c[W];
      led_d[1] = (res_c == '0);
    end else begin
      led_d = '0;
    end
  end

  // State registers; synchroniser and debounced level reset to the released state.
  always_ff @(posedge ADC_CLK_10 or negedge RST_N) begin
    if (!RST_N) begin
      key_sync_q <= 2'b11;
      key_db_q   <= 1'b1;
      db_cnt_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      mode_q     <= MODE_COMPARE;
      mode_chg_q <= 1'b0;
      result_q   <= '0;
      led_q      <= '0;
      settle_q   <= '0;
      valid_q    <= 1'b0;
      pre_q      <= '0;
      dir_up_q   <= 1'b1;
    end else begin
      key_sync_q <= {key_sync_q[0], key_adv_n};
      key_db_q   <= key_db_d;
      db_cnt_q   <= db_cnt_d;
      a_q        <= op_a;
      b_q        <= op_b;
      sel_q      <= sub_sel;
      mode_q     <= mode_d;
      mode_chg_q <= adv_c;
      result_q   <= result_d;
      led_q      <= led_d;
      settle_q   <= settle_d;
      valid_q    <= valid_d;
      pre_q      <= pre_d;
      dir_up_q   <= dir_up_d;
    end
  end

  assign mode         = mode_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign led          = led_q;
  assign mode_changed = mode_chg_q;

endmodule

// File: tb/tb_alu_mode_ctrl.sv
// tb_alu_mode_ctrl: directed table-driven bench for alu_mode_ctrl
// (W=4, LED_W=4, DEBOUNCE_CYCLES=4, PATTERN_DIV=3).
module tb_alu_mode_ctrl;

  localparam int unsigned W     = 4;
  localparam int unsigned LED_W = 4;
  localparam int unsigned NVEC  = 19;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_n = 1'b1;
  logic [W-1:0]     a     = '0;
  logic [W-1:0]     b     = '0;
  logic [1:0]       sel   = '0;
  logic [1:0]       mode;
  logic [2*W-1:0]   result;
  logic             result_valid;
  logic [LED_W-1:0] led;
  logic             mode_changed;

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;

  typedef struct {
    logic [1:0]       m;
    logic [W-1:0]     va;
    logic [W-1:0]     vb;
    logic [1:0]       s;
    logic [2*W-1:0]   r;
    logic [LED_W-1:0] l;
  } vec_t;

  vec_t vecs [NVEC];

  alu_mode_ctrl #(
    .W(W), .LED_W(LED_W), .DEBOUNCE_CYCLES(4), .PATTERN_DIV(3)
  ) dut (
    .ADC_CLK_10   (clk),
    .RST_N        (rst_n),
    .key_adv_n    (key_n),
    .op_a         (a),
    .op_b         (b),
    .sub_sel      (sel),
    .mode         (mode),
    .result       (result),
    .result_valid (result_valid),
    .led          (led),
    .mode_changed (mode_changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mode_changed === 1'b1) pulse_cnt <= pulse_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_press(output bit seen);
    key_n = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (mode_changed === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("press_timeout", 32'(0), 32'(1));
  endtask

  task automatic release_key;
    key_n = 1'b1;
    repeat (10) tick();
  endtask

  task automatic press_to(input logic [1:0] target);
    bit seen;
    for (int n = 0; n < 4 && mode != target; n++) begin
      do_press(seen);
      release_key();
    end
    chk("mode_reach", 32'(mode), 32'(target));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mode"},  32'(mode),         32'(0));
    chk({tag, "_res"},   32'(result),       32'(0));
    chk({tag, "_valid"}, 32'(result_valid), 32'(0));
    chk({tag, "_led"},   32'(led),          32'(0));
    chk({tag, "_mchg"},  32'(mode_changed), 32'(0));
  endtask

  initial begin
    bit seen;
    int base;
    int bseq [6];
    int rseq [4];
    logic [1:0]       exp_mode;
    logic [LED_W-1:0] prev;
    logic [LED_W-1:0] cnt_exp;

    vecs[0]  = '{2'd0, 4'h5, 4'h5, 2'd0, 8'h01, 4'h0};
    vecs[1]  = '{2'd0, 4'h5, 4'h6, 2'd0, 8'h00, 4'h0};
    vecs[2]  = '{2'd0, 4'h9, 4'h3, 2'd1, 8'h01, 4'h0};
    vecs[3]  = '{2'd0, 4'h3, 4'h9, 2'd1, 8'h00, 4'h0};
    vecs[4]  = '{2'd0, 4'h3, 4'h9, 2'd2, 8'h01, 4'h0};
    vecs[5]  = '{2'd0, 4'h3, 4'h9, 2'd3, 8'h09, 4'h0};
    vecs[6]  = '{2'd0, 4'hF, 4'h2, 2'd3, 8'h0F, 4'h0};
    vecs[7]  = '{2'd1, 4'hC, 4'hA, 2'd0, 8'h08, 4'h0};
    vecs[8]  = '{2'd1, 4'hC, 4'hA, 2'd1, 8'h0E, 4'h0};
    vecs[9]  = '{2'd1, 4'hC, 4'hA, 2'd2, 8'h06, 4'h0};
    vecs[10] = '{2'd1, 4'hC, 4'hA, 2'd3, 8'h03, 4'h0};
    vecs[11] = '{2'd2, 4'hF, 4'h1, 2'd0, 8'h10, 4'h1};
    vecs[12] = '{2'd2, 4'h3, 4'h5, 2'd1, 8'h1E, 4'h1};
    vecs[13] = '{2'd2, 4'h3, 4'h5, 2'd2, 8'h0F, 4'h0};
    vecs[14] = '{2'd2, 4'h5, 4'h5, 2'd1, 8'h00, 4'h2};
    vecs[15] = '{2'd2, 4'hA, 4'h0, 2'd3, 8'h14, 4'h1};
    vecs[16] = '{2'd2, 4'hF, 4'hF, 2'd2, 8'hE1, 4'h0};
    vecs[17] = '{2'd2, 4'h0, 4'h0, 2'd0, 8'h00, 4'h2};
    vecs[18] = '{2'd2, 4'h5, 4'h3, 2'd3, 8'h0A, 4'h0};
    bseq = '{2, 4, 8, 4, 2, 1};
    rseq = '{2, 4, 8, 1};

    // Reset state and valid ramp (valid from the 3rd clock).
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); chk("valid_clk1", 32'(result_valid), 32'(0));
    tick(); chk("valid_clk2", 32'(result_valid), 32'(0));
    tick(); chk("valid_clk3", 32'(result_valid), 32'(1));

    // Table-driven operations across COMPARE, LOGIC and ARITH.
    for (int i = 0; i < int'(NVEC); i++) begin
      press_to(vecs[i].m);
      a = vecs[i].va; b = vecs[i].vb; sel = vecs[i].s;
      tick(); tick();
      chk($sformatf("vec%0d_res", i),   32'(result),       32'(vecs[i].r));
      chk($sformatf("vec%0d_led", i),   32'(led),          32'(vecs[i].l));
      chk($sformatf("vec%0d_valid", i), 32'(result_valid), 32'(1));
    end

    // PATTERN entry and bounce with one step every 3 cycles.
    a = '0; b = '0; sel = 2'd0;
    tick();
    do_press(seen);
    key_n = 1'b1;
    chk("pat_mode", 32'(mode), 32'(3));
    chk("pat_entry_led", 32'(led), 32'(1));
    prev = 4'h1;
    for (int i = 0; i < 6; i++) begin
      tick(); tick();
      chk($sformatf("bounce_hold%0d", i), 32'(led), 32'(prev));
      tick();
      chk($sformatf("bounce_step%0d", i), 32'(led), 32'(bseq[i]));
      prev = LED_W'(bseq[i]);
    end

    // Rotate-left with wrap from the top bit.
    sel = 2'd1;
    for (int i = 0; i < 4; i++) begin
      repeat (3) tick();
      chk($sformatf("rotate%0d", i), 32'(led), 32'(rseq[i]));
    end

    // Binary count through the all-ones wrap.
    sel = 2'd2;
    cnt_exp = led;
    for (int i = 0; i < 15; i++) begin
      repeat (3) tick();
      cnt_exp = cnt_exp + LED_W'(1);
      chk($sformatf("count%0d", i), 32'(led), 32'(cnt_exp));
    end

    // Freeze holds, then switching to bounce with a non-one-hot value reloads.
    sel = 2'd3;
    repeat (6) tick();
    chk("freeze", 32'(led), 32'(0));
    sel = 2'd0;
    tick(); tick();
    chk("reload", 32'(led), 32'(1));
    tick();
    chk("reload_step", 32'(led), 32'(2));

    // Leaving PATTERN clears led together with the mode update.
    do_press(seen);
    chk("leave_mode", 32'(mode), 32'(0));
    chk("leave_led", 32'(led), 32'(0));
    chk("leave_valid", 32'(result_valid), 32'(0));
    release_key();

    // Short glitches are rejected; a long hold gives exactly one advance.
    base = pulse_cnt;
    for (int i = 0; i < 3; i++) begin
      key_n = 1'b0; repeat (2) tick();
      key_n = 1'b1; repeat (3) tick();
    end
    chk("glitch_none", 32'(pulse_cnt - base), 32'(0));
    key_n = 1'b0; repeat (10) tick();
    key_n = 1'b1; repeat (10) tick();
    chk("glitch_pulses", 32'(pulse_cnt - base), 32'(1));
    chk("glitch_mode", 32'(mode), 32'(1));

    // Asynchronous reset in the middle of a debounce.
    a = 4'h7; b = 4'h1; sel = 2'd1;
    repeat (3) tick();
    chk("pre_rst_res", 32'(result), 32'(7));
    key_n = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_db");
    key_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = pulse_cnt;
    repeat (20) tick();
    chk("rst_db_nopulse", 32'(pulse_cnt - base), 32'(0));
    chk("rst_db_mode", 32'(mode), 32'(0));

    // Asynchronous reset in the middle of a pattern.
    sel = 2'd0;
    press_to(2'd3);
    chk("pat2_led", 32'(led), 32'(8));
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_pat");
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = pulse_cnt;
    repeat (20) tick();
    chk("rst_pat_nopulse", 32'(pulse_cnt - base), 32'(0));
    chk("rst_pat_valid", 32'(result_valid), 32'(1));

    // Four advances: 1,2,3,0 with result_valid low for exactly two cycles each.
    exp_mode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      exp_mode = exp_mode + 2'd1;
      do_press(seen);
      chk($sformatf("seq%0d_mode", i), 32'(mode), 32'(exp_mode));
      chk($sformatf("seq%0d_v0", i), 32'(result_valid), 32'(0));
      tick();
      chk($sformatf("seq%0d_v1", i), 32'(result_valid), 32'(0));
      tick();
      chk($sformatf("seq%0d_v2", i), 32'(result_valid), 32'(1));
      if (i == 3) chk("seq_led_off", 32'(led), 32'(0));
      release_key();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mode_ctrl.md
Name: alu_mode_ctrl

Overview:
Parametrised successor to the board-top mode/operation selector. It takes two W-bit operands, a 2-bit sub-operation select and a raw active-low push-button, then produces a registered result, LED flags and a current-mode indication.
- Adds what the previous generation lacked: input synchronisation, button debounce, a clean one-pulse-per-press mode advance and a timed LED pattern engine.
- Sits between the board switches/keys and the seven-segment/LED drivers.

Parameters:
W, 4, operand width in bits; legal W >= 2
LED_W, 10, LED output width; legal LED_W >= 2
DEBOUNCE_CYCLES, 100000, consecutive stable samples needed to accept a button level (10 ms at 10 MHz)
PATTERN_DIV, 1000000, clock cycles per LED pattern step (0.1 s at 10 MHz)
AUTO_PERIOD, 50000000, auto-advance period in cycles; used only with AUTO_CYCLE_EN

Ports:
ADC_CLK_10  in  1  system clock; all flops on its rising edge
RST_N  in  1  asynchronous active-low reset
key_adv_n  in  1  raw active-low mode-advance button, asynchronous to the clock
op_a  in  W  operand A (switches, asynchronous)
op_b  in  W  operand B (switches, asynchronous)
sub_sel  in  2  sub-operation select (switches, asynchronous)
mode  out  2  current mode: 0 COMPARE, 1 LOGIC, 2 ARITH, 3 PATTERN
result  out  2W  registered result, zero-extended
result_valid  out  1  result reflects current mode and inputs
led  out  LED_W  registered LED drive
mode_changed  out  1  one-cycle pulse on every mode advance

Behaviour:
Reset (RST_N low, asynchronous):
- mode=0, result=0, result_valid=0, led=0, mode_changed=0.
- Synchronisers, debounce counter and pattern state all cleared.
- Debounced key level resets to 1 (released).

Synchronisation:
- key_adv_n passes through a 2-flop synchroniser.
- op_a, op_b and sub_sel are captured in one input register stage.

Debounce:
- The counter increments while the synchronised level differs from the debounced level, and clears when they match.
- On reaching DEBOUNCE_CYCLES-1, the debounced level takes the new value and the counter clears.
- A debounced 1->0 transition generates exactly one press pulse. Release generates nothing.

Mode advance:
- On a press pulse, mode <= mode+1, wrapping 3->0.
- mode_changed pulses high for 1 cycle, aligned with the new mode value.

Result path:
- result is registered from the input-register values, giving latency 2 cycles from operand change to result.
- result_valid goes 0 in the cycle mode changes and returns to 1 two cycles later. After reset it is 1 from the 3rd clock onward.
- COMPARE: sub_sel 0 A==B, 1 A>B, 2 A<B (unsigned, 1-bit flag in result[0]); 3 max(A,B).
- LOGIC: sub_sel 0 A&B, 1 A|B, 2 A^B, 3 ~A (W bits).
- ARITH:
  - sub_sel 0: A+B (W+1 bits).
  - sub_sel 1: A-B mod 2^W, with borrow in bit W.
  - sub_sel 2: A*B (full 2W bits).
  - sub_sel 3: A<<1, with bit W = A[W-1].
- PATTERN: result=0.
- Unused upper result bits are 0.

LED:
- COMPARE and LOGIC: led=0.
- ARITH: led[0]=result bit W (carry/borrow/shift-out); led[1]=(result==0); other bits 0. led is registered alongside result.
- PATTERN:
  - Prescaler counts to PATTERN_DIV-1, then steps.
  - On entry to PATTERN: led=1 (bit 0 lit), direction=up, prescaler=0.
  - sub_sel 0 bounce: one lit bit moves up, reverses at bit LED_W-1, reverses again at bit 0, with no dwell at the ends.
  - sub_sel 1 rotate-left: wraps bit LED_W-1 -> bit 0.
  - sub_sel 2 binary count: wraps at all-ones.
  - sub_sel 3 freeze: hold the current value.
  - A change of sub_sel inside PATTERN does not reload the pattern; the new rule applies from the next step. Exception: switching into bounce or rotate with other than a one-hot led reloads led=1.
- Leaving PATTERN clears led in the same cycle that mode updates.

Simultaneous events:
- Press and pattern step in the same cycle: the mode change wins and the step is discarded.
- Reset mid-debounce or mid-pattern: all state cleared, with no pending press.

Optional Feature:
AUTO_CYCLE_EN
- Defined: a free-running timer generates an advance every AUTO_PERIOD cycles, treated exactly like a press. A real press also advances and restarts the timer at 0. Timer reset value is 0.
- Undefined: the timer is absent and only debounced presses advance the mode.

Test Plan:
- W=4, DEBOUNCE_CYCLES=4: hold key_adv_n low with 2-cycle glitches, then low for 10 cycles -> exactly one mode_changed pulse; mode 0->1.
- Mode 2, op_a=4'hF, op_b=4'h1, sub_sel=0 -> result=8'h10, led[0]=1, led[1]=0, 2 cycles after inputs settle.
- Mode 2, op_a=4'h3, op_b=4'h5, sub_sel=1 -> result=8'h1E (borrow=1, diff=E); sub_sel=2 -> result=8'h0F.
- PATTERN_DIV=3, LED_W=4, mode 3, sub_sel=0 -> led steps 0001,0010,0100,1000,0100,0010,0001, one step every 3 cycles.
- Four presses from mode 0 -> mode sequence 1,2,3,0; result_valid low exactly 2 cycles after each change; led=0 after leaving PATTERN.
- Assert RST_N low mid-debounce and mid-pattern -> all outputs 0 immediately (asynchronous); after release, no spurious mode_changed.
